// File: rtl/trace_drain_engine.sv
// trace_drain_engine: drains the circular trace SRAM in FIFO order onto a valid/ready stream
module trace_drain_engine #(
  parameter int NumFields     = 5,
  parameter int AddrWidth     = 15,
  parameter int DataWidth     = 32,
  parameter int AddrBufBytes  = 16380,
  parameter int InstrBufBytes = 16384
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     mode_i,
  input  logic                           clr_i,
  input  logic                           drain_en_i,
  input  logic                           wr_push_i,
  output logic [NumFields-1:0]           mem_req_o,
  output logic [NumFields*AddrWidth-1:0] mem_addr_o,
  input  logic [NumFields*DataWidth-1:0] mem_rdata_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [NumFields*DataWidth-1:0] m_data_o,
  output logic                           read_ack_o,
  output logic [AddrWidth-1:0]           rd_ptr_o,
  output logic [12:0]                    occupancy_o,
  output logic                           overflow_o,
  output logic [15:0]                    drop_cnt_o,
  input  logic                           wm_en_i,
  input  logic [12:0]                    wm_lvl_i,
  output logic                           wm_irq_o
);
  localparam int PW = AddrWidth + 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_e;
  state_e state;
  logic [1:0] mode_q;
  logic instr, push, issue, full, accept, go;
  logic [PW-1:0] incr, size, sum;
  logic [AddrWidth-1:0] nxt;
  logic [12:0] cap;
  assign instr = mode_q == 2'd1;
  assign incr = instr ? PW'(4) : PW'(4 * NumFields);
  assign size = instr ? PW'(InstrBufBytes) : PW'(AddrBufBytes);
  assign cap = instr ? 13'(InstrBufBytes / 4) : 13'(AddrBufBytes / (4 * NumFields));
  assign sum = {1'b0, rd_ptr_o} + incr;
  assign nxt = AddrWidth'(sum >= size ? sum - size : sum);
  assign push = wr_push_i && !mode_q[1];
  assign issue = state == REQ;
  assign full = occupancy_o == cap;
  assign accept = m_valid_o && m_ready_i;
  assign go = !mode_q[1] && drain_en_i && occupancy_o != '0;
  assign read_ack_o = accept;
  always_comb begin
    mem_req_o = '0;
    mem_addr_o = '0;
    for (int i = 0; i < NumFields; i++)
      if (issue && (!instr || i == 0)) begin
        mem_req_o[i] = 1'b1;
        mem_addr_o[i*AddrWidth +: AddrWidth] = rd_ptr_o + AddrWidth'(4 * i);
      end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state       <= IDLE;
      mode_q      <= rst_i ? 2'd0 : mode_i;
      rd_ptr_o    <= '0;
      occupancy_o <= '0;
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
      wm_irq_o    <= 1'b0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
    end else begin
      wm_irq_o <= wm_en_i && occupancy_o >= wm_lvl_i;
      // a push into a full buffer overwrites the oldest entry, so the reader skips it
      if (issue) begin
        rd_ptr_o <= nxt;
        if (!push) occupancy_o <= occupancy_o - 13'd1;
      end else if (push && full) begin
        rd_ptr_o   <= nxt;
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end else if (push) begin
        occupancy_o <= occupancy_o + 13'd1;
      end
      case (state)
        IDLE: if (go) state <= REQ;
        REQ:  state <= RESP;
        RESP: begin
          state     <= HOLD;
          m_valid_o <= 1'b1;
          m_data_o  <= instr ? {{(NumFields-1)*DataWidth{1'b0}}, mem_rdata_i[DataWidth-1:0]} : mem_rdata_i;
        end
        HOLD: if (accept) begin
          m_valid_o <= 1'b0;
          state     <= go ? REQ : IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trace_drain_engine.sv
// tb_trace_drain_engine: randomized and directed checks against a behavioural drain model
module tb_trace_drain_engine;
  logic clk, rst_i, clr_i, drain_en_i, wr_push_i, m_ready_i, wm_en_i;
  logic [1:0] mode_i;
  logic [12:0] wm_lvl_i;
  logic [4:0] mem_req_o;
  logic [74:0] mem_addr_o;
  logic [159:0] mem_rdata_i, m_data_o;
  logic m_valid_o, read_ack_o, overflow_o, wm_irq_o;
  logic [14:0] rd_ptr_o;
  logic [12:0] occupancy_o;
  logic [15:0] drop_cnt_o;

  trace_drain_engine dut (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .clr_i(clr_i), .drain_en_i(drain_en_i),
    .wr_push_i(wr_push_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .read_ack_o(read_ack_o),
    .rd_ptr_o(rd_ptr_o), .occupancy_o(occupancy_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .wm_en_i(wm_en_i), .wm_lvl_i(wm_lvl_i), .wm_irq_o(wm_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, ack_count = 0, req_count = 0;
  bit cap_first = 0;
  logic [4:0] first_req, req_prev;
  logic [74:0] first_addr, addr_prev;

  // reference state: buffer bookkeeping plus the single entry travelling to the stream
  int md_mode, md_occ, md_ptr, md_drop, md_raddr;
  bit md_ovf, md_irq, md_valid, md_issue, md_resp;
  logic [159:0] md_data;

  function automatic int incr_f(int m); return m == 1 ? 4 : 20; endfunction
  function automatic int size_f(int m); return m == 1 ? 16384 : 16380; endfunction
  function automatic int cap_f(int m); return m == 1 ? 4096 : 819; endfunction
  function automatic int adv(int p, int m);
    p += incr_f(m);
    if (p >= size_f(m)) p -= size_f(m);
    return p;
  endfunction
  function automatic logic [31:0] mem_word(int a);
    return 32'(a) * 32'h9E3779B1 + 32'h0123_4567;
  endfunction
  function automatic logic [159:0] entry(int a, int m);
    logic [159:0] e;
    e = '0;
    for (int i = 0; i < 5; i++) if (m != 1 || i == 0) e[i*32 +: 32] = mem_word(a + 4 * i);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset(input int m);
    md_mode = m; md_occ = 0; md_ptr = 0; md_drop = 0; md_raddr = 0;
    md_ovf = 0; md_irq = 0; md_valid = 0; md_issue = 0; md_resp = 0; md_data = '0;
  endtask

  task automatic model_update();
    bit en, psh, acc, nis;
    int occ0;
    if (rst_i) model_reset(0);
    else if (clr_i) model_reset(int'(mode_i));
    else begin
      en = md_mode < 2;
      psh = wr_push_i && en;
      acc = md_valid && m_ready_i;
      occ0 = md_occ;
      nis = en && drain_en_i && occ0 > 0 && !md_issue && !md_resp && (!md_valid || acc);
      md_irq = wm_en_i && occ0 >= int'(wm_lvl_i);
      if (md_resp) begin
        md_valid = 1;
        md_data = entry(md_raddr, md_mode);
      end else if (acc) md_valid = 0;
      md_resp = md_issue;
      md_raddr = md_ptr;
      if (md_issue) begin
        if (!psh) md_occ--;
        md_ptr = adv(md_ptr, md_mode);
      end else if (psh) begin
        if (md_occ == cap_f(md_mode)) begin
          md_ptr = adv(md_ptr, md_mode);
          md_ovf = 1;
          if (md_drop < 65535) md_drop++;
        end else md_occ++;
      end
      md_issue = nis;
    end
  endtask

  task automatic compare();
    logic [4:0] er;
    logic [74:0] ea;
    er = '0; ea = '0;
    if (md_issue)
      for (int i = 0; i < 5; i++)
        if (md_mode != 1 || i == 0) begin
          er[i] = 1'b1;
          ea[i*15 +: 15] = 15'(md_ptr + 4 * i);
        end
    chk("mem_req", mem_req_o, er);
    chk("mem_addr", mem_addr_o, ea);
    chk("m_valid", m_valid_o, md_valid);
    chk("m_data", m_data_o, md_data);
    chk("read_ack", read_ack_o, md_valid && m_ready_i);
    chk("rd_ptr", rd_ptr_o, md_ptr);
    chk("occupancy", occupancy_o, md_occ);
    chk("overflow", overflow_o, md_ovf);
    chk("drop_cnt", drop_cnt_o, md_drop);
    chk("wm_irq", wm_irq_o, md_irq);
    if (read_ack_o) ack_count++;
    if (mem_req_o != 0) req_count++;
  endtask

  task automatic step();
    #1;
    compare();
    model_update();
    if (cap_first && mem_req_o != 0) begin
      first_req = mem_req_o; first_addr = mem_addr_o; cap_first = 0;
    end
    req_prev = mem_req_o;
    addr_prev = mem_addr_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      mem_rdata_i[i*32 +: 32] = req_prev[i] ? mem_word(int'(addr_prev[i*15 +: 15])) : $urandom;
  endtask

  task automatic do_clr(input logic [1:0] m);
    clr_i = 1; mode_i = m; step(); clr_i = 0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && mem_req_o == 0; k++) step();
    chk("wait_req", mem_req_o != 0, 1);
  endtask

  int a0, r0;
  initial begin
    rst_i = 1; clr_i = 0; mode_i = 0; drain_en_i = 0; wr_push_i = 0; m_ready_i = 0;
    wm_en_i = 0; wm_lvl_i = 0; mem_rdata_i = '0;
    model_reset(0);
    @(posedge clk); #1;
    step(); step();
    rst_i = 0;
    chk("rst_occ", occupancy_o, 0);
    chk("rst_ptr", rd_ptr_o, 0);
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    // three entries in address mode
    drain_en_i = 1; m_ready_i = 1; cap_first = 1; a0 = ack_count;
    repeat (3) begin wr_push_i = 1; step(); end
    wr_push_i = 0;
    repeat (20) step();
    chk("t1_addr", first_addr, {15'd16, 15'd12, 15'd8, 15'd4, 15'd0});
    chk("t1_req", first_req, 5'h1f);
    chk("t1_acks", ack_count - a0, 3);
    chk("t1_ptr", rd_ptr_o, 60);
    chk("t1_occ", occupancy_o, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      wr_push_i = $urandom_range(0, 9) < 4;
      drain_en_i = $urandom_range(0, 9) < 8;
      m_ready_i = $urandom_range(0, 9) < 6;
      wm_en_i = 1'($urandom_range(0, 1));
      wm_lvl_i = 13'($urandom_range(0, 6));
      clr_i = $urandom_range(0, 99) == 0;
      mode_i = 2'($urandom_range(0, 3));
      rst_i = $urandom_range(0, 299) == 0;
      step();
    end
    rst_i = 0; wr_push_i = 0; wm_en_i = 0;
    // lapped reader in address mode
    do_clr(0);
    drain_en_i = 0; m_ready_i = 1;
    repeat (820) begin wr_push_i = 1; step(); end
    wr_push_i = 0;
    step();
    chk("ovf_occ", occupancy_o, 819);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drop", drop_cnt_o, 1);
    chk("ovf_ptr", rd_ptr_o, 20);
    cap_first = 1; a0 = ack_count; drain_en_i = 1;
    for (int k = 0; k < 4000 && ack_count - a0 < 819; k++) step();
    chk("ovf_acks", ack_count - a0, 819);
    chk("ovf_first", first_addr[14:0], 20);
    chk("ovf_empty", occupancy_o, 0);
    // instruction-mode wrap
    do_clr(1);
    drain_en_i = 1; m_ready_i = 1;
    repeat (4095) begin
      wr_push_i = 1; step(); wr_push_i = 0; repeat (3) step();
    end
    repeat (4) step();
    chk("ins_ptr", rd_ptr_o, 16380);
    cap_first = 1; wr_push_i = 1; step(); wr_push_i = 0;
    repeat (6) step();
    chk("ins_req", first_req, 5'h01);
    chk("ins_addr", first_addr[14:0], 16380);
    chk("ins_wrap", rd_ptr_o, 0);
    // stalled stream
    do_clr(0);
    drain_en_i = 1; m_ready_i = 0; wr_push_i = 1; step(); wr_push_i = 0;
    for (int k = 0; k < 10 && !m_valid_o; k++) step();
    chk("hold_valid", m_valid_o, 1);
    r0 = req_count; a0 = ack_count;
    repeat (10) begin wr_push_i = 1; step(); end
    wr_push_i = 0;
    chk("hold_data", m_data_o, entry(0, 0));
    chk("hold_noreq", req_count - r0, 0);
    chk("hold_noack", ack_count - a0, 0);
    m_ready_i = 1; step(); m_ready_i = 0;
    chk("hold_ack", ack_count - a0, 1);
    // watermark
    do_clr(0);
    drain_en_i = 0; m_ready_i = 1; wm_en_i = 1; wm_lvl_i = 4;
    repeat (4) begin wr_push_i = 1; step(); end
    wr_push_i = 0;
    chk("wm_pre", wm_irq_o, 0);
    step();
    chk("wm_rise", wm_irq_o, 1);
    drain_en_i = 1; step(); drain_en_i = 0; step(); step();
    chk("wm_fall", wm_irq_o, 0);
    chk("wm_occ", occupancy_o, 3);
    wm_en_i = 0; wm_lvl_i = 0; step(); step();
    chk("wm_off", wm_irq_o, 0);
    // clear during response
    do_clr(0);
    drain_en_i = 1; m_ready_i = 1; wr_push_i = 1; step(); wr_push_i = 0;
    wait_req();
    step();
    clr_i = 1; mode_i = 1; step(); clr_i = 0;
    chk("clr_valid", m_valid_o, 0);
    chk("clr_ptr", rd_ptr_o, 0);
    chk("clr_occ", occupancy_o, 0);
    chk("clr_ovf", overflow_o, 0);
    wr_push_i = 1; step(); wr_push_i = 0;
    wait_req();
    chk("clr_mode", mem_req_o, 5'h01);
    repeat (5) step();
    rst_i = 1; clr_i = 1; mode_i = 1; step(); rst_i = 0; clr_i = 0;
    wr_push_i = 1; step(); wr_push_i = 0;
    wait_req();
    chk("rst_mode", mem_req_o, 5'h1f);
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
